// File: rtl/cv32e40p_apu_core_pkg.sv
// APU interface widths shared between the core and its auxiliary processing units.
package cv32e40p_apu_core_pkg;

  localparam int unsigned APU_NARGS_CPU    = 3;
  localparam int unsigned APU_WOP_CPU      = 6;
  localparam int unsigned APU_NDSFLAGS_CPU = 15;
  localparam int unsigned APU_NUSFLAGS_CPU = 5;

endpackage

// File: rtl/cv32e40p_apu_seq_pkg.sv
// Types and constants for the APU-to-vector-accelerator sequencer.
package cv32e40p_apu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LSU,
    ISSUE,
    WAIT_RESP,
    RESP
  } apu_seq_state_e;

  // Opcode low bits that mark a vector memory operation.
  localparam logic [1:0] APU_MEMOP = 2'd1;

  // Upstream flag bit that reports a response timeout.
  localparam int unsigned APU_ERR_FLAG_BIT = 0;

  // Timer width able to hold TIMEOUT_CYCLES; never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/cv32e40p_apu_timeout_cnt.sv
// Saturating response timer; flags expiry one cycle before the limit is reached
// so the owner can leave its wait state exactly after `limit` cycles.
module cv32e40p_apu_timeout_cnt #(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;

  // Count while enabled; hold at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    if (rst_i || clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  // A zero limit disables the timeout entirely.
  assign expired_o = (limit_i != '0) && (count_q == limit_i - WIDTH'(1));

endmodule

// File: rtl/cv32e40p_apu_vec_sequencer.sv
// Bridges the core APU port to the vector accelerator: one op in flight,
// data-memory master handover for vector memory ops, bounded response wait.
module cv32e40p_apu_vec_sequencer
  import cv32e40p_apu_core_pkg::*;
  import cv32e40p_apu_seq_pkg::*;
#(
  parameter int unsigned NARGS          = APU_NARGS_CPU,
  parameter int unsigned WOP            = APU_WOP_CPU,
  parameter int unsigned NDSFLAGS       = APU_NDSFLAGS_CPU,
  parameter int unsigned NUSFLAGS       = APU_NUSFLAGS_CPU,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // core side
  input  logic                  apu_req_i,
  output logic                  apu_gnt_o,
  input  logic [NARGS*32-1:0]   apu_operands_i,
  input  logic [WOP-1:0]        apu_op_i,
  input  logic [NDSFLAGS-1:0]   apu_flags_i,
  output logic                  apu_rvalid_o,
  output logic [31:0]           apu_result_o,
  output logic [NUSFLAGS-1:0]   apu_flags_o,
  // accelerator side
  output logic                  acc_req_o,
  input  logic                  acc_gnt_i,
  output logic [NARGS*32-1:0]   acc_operands_o,
  output logic [WOP-1:0]        acc_op_o,
  output logic [NDSFLAGS-1:0]   acc_flags_o,
  input  logic                  acc_rvalid_i,
  input  logic [31:0]           acc_result_i,
  input  logic [NUSFLAGS-1:0]   acc_flags_i,
  // memory handover and status
  input  logic                  lsu_busy_i,
  output logic                  mem_master_sel_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam int unsigned          TW        = timer_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]        LIMIT     = TW'(TIMEOUT_CYCLES);
  localparam logic [NUSFLAGS-1:0]  ERR_FLAGS = NUSFLAGS'(1) << APU_ERR_FLAG_BIT;

  apu_seq_state_e        state_q, state_d;
  logic                  timer_expired;
  logic                  is_memop;

  logic [NARGS*32-1:0]   operands_q;
  logic [WOP-1:0]        op_q;
  logic [NDSFLAGS-1:0]   flags_q;
  logic [31:0]           result_q;
  logic [NUSFLAGS-1:0]   rsp_flags_q;
  logic                  mem_sel_q;
  logic                  timeout_q;

  assign is_memop = (apu_op_i[1:0] == APU_MEMOP);

  // Timer restarts on accelerator grant and runs only while awaiting the reply.
  cv32e40p_apu_timeout_cnt #(
    .WIDTH (TW)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   ((state_q == ISSUE) && acc_gnt_i),
    .enable_i  (state_q == WAIT_RESP),
    .limit_i   (LIMIT),
    .expired_o (timer_expired)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a reply in the timeout cycle is taken as a real reply.
  always_comb begin
    // NOTE: defaulting every always_comb target first keeps each path assigned,
    // which is what prevents latch inference.
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (apu_req_i) state_d = is_memop ? WAIT_LSU : ISSUE;
      WAIT_LSU:  if (!lsu_busy_i) state_d = ISSUE;
      ISSUE:     if (acc_gnt_i) state_d = WAIT_RESP;
      WAIT_RESP: if (acc_rvalid_i || timer_expired) state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Payload capture, memory-port ownership, response capture and sticky timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      operands_q  <= '0;
      op_q        <= '0;
      flags_q     <= '0;
      result_q    <= '0;
      rsp_flags_q <= '0;
      mem_sel_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      if ((state_q == IDLE) && apu_req_i) begin
        operands_q <= apu_operands_i;
        op_q       <= apu_op_i;
        flags_q    <= apu_flags_i;
      end
      // Hand the data-memory port over only once the core LSU has drained.
      if ((state_q == WAIT_LSU) && !lsu_busy_i) begin
        mem_sel_q <= 1'b1;
      end
      if (state_q == RESP) begin
        mem_sel_q <= 1'b0;
      end
      if (state_q == WAIT_RESP) begin
        if (acc_rvalid_i) begin
          result_q    <= acc_result_i;
          rsp_flags_q <= acc_flags_i;
        end else if (timer_expired) begin
          result_q    <= '0;
          rsp_flags_q <= ERR_FLAGS;
          timeout_q   <= 1'b1;
        end
      end
    end
  end

  assign apu_gnt_o        = (state_q == IDLE);
  assign acc_req_o        = (state_q == ISSUE);
  assign apu_rvalid_o     = (state_q == RESP);
  assign busy_o           = (state_q != IDLE);
  assign acc_operands_o   = operands_q;
  assign acc_op_o         = op_q;
  assign acc_flags_o      = flags_q;
  assign apu_result_o     = result_q;
  assign apu_flags_o      = rsp_flags_q;
  assign mem_master_sel_o = mem_sel_q;
  assign timeout_o        = timeout_q;

endmodule
